// File: rtl/alu_dword_seq_if.sv
// Request/response handshake between the issue stage and the 64-bit ALU sequencer.
// master = issue stage / consumer side, slave = sequencer side.
interface alu_dword_seq_if #(
  parameter int HALF_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [2*HALF_W-1:0]   req_a;
  logic [2*HALF_W-1:0]   req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*HALF_W-1:0]   rsp_result;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_dword_seq.sv
// Runs 64-bit ADD/ADC/SUB/AND through a 32-bit ALU in two passes (low, then high),
// chaining carry between halves and keeping a persistent {N,Z,C,V} flag register.
module alu_dword_seq #(
  parameter int         HALF_W     = 32,
  parameter logic [3:0] INIT_FLAGS = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  alu_dword_seq_if.slave    bus,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic [HALF_W-1:0] alu_in1,
  output logic [HALF_W-1:0] alu_in2,
  output logic              alu_carry,
  output logic [1:0]        alu_op,
  input  logic [HALF_W-1:0] alu_out,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v
);
  localparam int W = 2 * HALF_W;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADC  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_AND  = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       op_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             cin_reg;
  logic [HALF_W-1:0] res_lo_reg;
  logic             lo_c_reg;
  logic             lo_z_reg;
  logic [W-1:0]     result_reg;
  logic [3:0]       flags_reg;

  logic             is_and;
  logic             invert_a;
  logic [W-1:0]     a_eff;

  // N comes from the high result's sign bit directly, so the ALU's N output is not needed.
  logic             unused_alu_n;
  assign unused_alu_n = alu_n;

  assign is_and   = (op_reg == OP_AND);
  assign invert_a = (op_reg == OP_SUB);

  // SUB is evaluated as B + ~A + 1, so A is bitwise inverted before it reaches the ALU.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_inv
      assign a_eff[gi] = a_reg[gi] ^ invert_a;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= OP_ADD;
      a_reg      <= '0;
      b_reg      <= '0;
      cin_reg    <= 1'b0;
      res_lo_reg <= '0;
      lo_c_reg   <= 1'b0;
      lo_z_reg   <= 1'b0;
      result_reg <= '0;
      flags_reg  <= INIT_FLAGS;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            op_reg  <= bus.req_op;
            a_reg   <= bus.req_a;
            b_reg   <= bus.req_b;
            cin_reg <= flags_reg[1];
          end
        end
        LO: begin
          res_lo_reg <= alu_out;
          lo_c_reg   <= alu_c;
          lo_z_reg   <= alu_z;
        end
        HI: begin
          result_reg <= {alu_out, res_lo_reg};
          flags_reg  <= {alu_out[HALF_W-1],
                         lo_z_reg & alu_z,
                         is_and ? 1'b0 : alu_c,
                         is_and ? 1'b0 : alu_v};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state_reg;
    alu_in1       = '0;
    alu_in2       = '0;
    alu_carry     = 1'b0;
    alu_op        = ALU_ADD;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_next = LO;
        end
      end
      LO: begin
        alu_in1 = a_eff[HALF_W-1:0];
        alu_in2 = b_reg[HALF_W-1:0];
        alu_op  = is_and ? ALU_AND : ALU_ADD;
        case (op_reg)
          OP_ADC:  alu_carry = cin_reg;
          OP_SUB:  alu_carry = 1'b1;
          default: alu_carry = 1'b0;
        endcase
        state_next = HI;
      end
      HI: begin
        alu_in1    = a_eff[W-1:HALF_W];
        alu_in2    = b_reg[W-1:HALF_W];
        alu_op     = is_and ? ALU_AND : ALU_ADD;
        alu_carry  = is_and ? 1'b0 : lo_c_reg;
        state_next = DONE;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.rsp_result = result_reg;
  assign flag_n = flags_reg[3];
  assign flag_z = flags_reg[2];
  assign flag_c = flags_reg[1];
  assign flag_v = flags_reg[0];

endmodule

// File: tb/tb_alu_dword_seq.sv
// Randomized scoreboard bench for alu_dword_seq; a golden 32-bit ALU is attached to the
// DUT's ALU ports and expected results come from plain 64-bit arithmetic.
module tb_alu_dword_seq;
  localparam int HALF_W = 32;
  localparam int W      = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_dword_seq_if #(.HALF_W(HALF_W)) bus();

  logic              flag_n, flag_z, flag_c, flag_v;
  logic [HALF_W-1:0] alu_in1, alu_in2, alu_out;
  logic              alu_carry, alu_n, alu_z, alu_c, alu_v;
  logic [1:0]        alu_op;
  logic [HALF_W:0]   alu_sum;

  alu_dword_seq #(.HALF_W(HALF_W), .INIT_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_carry(alu_carry), .alu_op(alu_op),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v)
  );

  always #5 clk = ~clk;

  // Golden combinational ALU: C is bit HALF_W of the sum, V is standard signed overflow.
  always_comb begin
    alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2} + {{HALF_W{1'b0}}, alu_carry};
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    if (alu_op == 2'b10) begin
      alu_out = alu_in1 & alu_in2;
    end else begin
      alu_out = alu_sum[HALF_W-1:0];
      alu_c   = alu_sum[HALF_W];
      alu_v   = (alu_in1[HALF_W-1] == alu_in2[HALF_W-1]) && (alu_out[HALF_W-1] != alu_in1[HALF_W-1]);
    end
    alu_n = alu_out[HALF_W-1];
    alu_z = (alu_out == '0);
  end

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] model_flags = 4'b0000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word 64-bit arithmetic, flags {N,Z,C,V}.
  task automatic ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic [3:0] f);
    logic [W:0] w;
    logic c, v;
    w = '0;
    case (op)
      2'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[W-1:0]; c = w[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'd1: begin
        w = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, model_flags[1]};
        r = w[W-1:0]; c = w[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'd2: begin
        r = b - a; c = (b >= a);
        v = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
      end
      default: begin
        r = a & b; c = 1'b0; v = 1'b0;
      end
    endcase
    f = {r[W-1], (r == '0), c, v};
  endtask

  // Monitor: compares every handshaken response against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=0x%0h required=no response", bus.rsp_result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_result", bus.rsp_result, e.r);
        check("rsp_flags", {flag_n, flag_z, flag_c, flag_v}, e.f);
        $display("RSP result=0x%016h nzcv=%b%b%b%b expected=0x%016h/%b",
                 bus.rsp_result, flag_n, flag_z, flag_c, flag_v, e.r, e.f);
      end
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout actual=%b required=1", bus.req_ready);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int bp, input bit chk_const,
                       input logic [W-1:0] const_r, input logic [3:0] const_f);
    exp_t e;
    logic [1:0]   exp_aluop;
    logic         exp_cin;
    logic [W-1:0] held;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    exp_aluop = (op == 2'd3) ? 2'b10 : 2'b00;
    exp_cin   = (op == 2'd1) ? model_flags[1] : (op == 2'd2);
    ref_model(op, a, b, e.r, e.f);
    model_flags = e.f;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("req_ready_lo", bus.req_ready, 1'b0);
    check("alu_op_lo", alu_op, exp_aluop);
    check("alu_carry_lo", alu_carry, exp_cin);
    @(posedge clk); #1;
    check("req_ready_hi", bus.req_ready, 1'b0);
    check("rsp_valid_hi", bus.rsp_valid, 1'b0);
    check("alu_op_hi", alu_op, exp_aluop);
    @(posedge clk); #1;
    check("rsp_valid_latency", bus.rsp_valid, 1'b1);
    check("alu_op_done", alu_op, 2'b00);
    if (chk_const) begin
      check("directed_result", bus.rsp_result, const_r);
      check("directed_flags", {flag_n, flag_z, flag_c, flag_v}, const_f);
    end
    held = bus.rsp_result;
    for (int i = 0; i < bp; i++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 2'($urandom_range(0, 3));
      bus.req_a     = {$urandom, $urandom};
      bus.req_b     = {$urandom, $urandom};
      @(posedge clk); #1;
      check("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_rsp_result", bus.rsp_result, held);
      check("bp_req_ready", bus.req_ready, 1'b0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, 1'b0);
    check("post_req_ready", bus.req_ready, 1'b1);
  endtask

  task automatic abort_during_hi();
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_a     = {$urandom, $urandom};
    bus.req_b     = {$urandom, $urandom};
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_flags = 4'b0000;
    check("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check("abort_req_ready", bus.req_ready, 1'b1);
    check("abort_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
    check("abort_result", bus.rsp_result, 64'd0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_rsp", bus.rsp_valid, 1'b0);
    end
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_result", bus.rsp_result, 64'd0);
    check("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
    check("rst_alu", {alu_in1, alu_in2, alu_carry, alu_op}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(2'd0, 64'h00000000_FFFFFFFF, 64'd1, 0, 1'b1, 64'h00000001_00000000, 4'b0000);
    issue(2'd0, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 0, 1'b1, 64'd0, 4'b0110);
    issue(2'd1, 64'd0, 64'd0, 0, 1'b1, 64'd1, 4'b0000);
    issue(2'd2, 64'd1, 64'd0, 0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 4'b1000);
    issue(2'd2, 64'd5, 64'd5, 0, 1'b1, 64'd0, 4'b0110);
    issue(2'd0, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 0, 1'b1, 64'h80000000_00000000, 4'b1001);
    issue(2'd3, 64'hF0F0F0F0_0000FFFF, 64'h0FF00FF0_FFFF0000, 0, 1'b1, 64'h00F000F0_00000000, 4'b0000);
    issue(2'd0, 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 5, 1'b0, 64'd0, 4'b0000);

    // Leave N set so the abort visibly restores the reset flags.
    issue(2'd2, 64'd1, 64'd0, 0, 1'b0, 64'd0, 4'b0000);
    abort_during_hi();

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = 64'hFFFFFFFF_FFFFFFFF;
        1:       ra = {32'd0, $urandom};
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0:       rb = {$urandom, 32'hFFFFFFFF};
        1:       rb = ra;
        default: rb = {$urandom, $urandom};
      endcase
      issue(2'($urandom_range(0, 3)), ra, rb, int'($urandom_range(0, 3)), 1'b0, 64'd0, 4'b0000);
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
